// File: rtl/router_ctrl.sv
// Packet router controller: routes a header/payload/parity byte stream to one of three destination FIFOs.
// Optional per-port idle timeout with FIFO soft reset is enabled by defining ROUTER_CTRL_TIMEOUT_EN.
module router_ctrl #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic [2:0] valid_out,
  output logic [2:0] write_enb,
  output logic [2:0] soft_reset,
  output logic       busy,
  output logic       lfd_state,
  output logic       parity_err,
  output logic [2:0] o_state_dbg
);

  // Source handshake: a byte on data_in is consumed at the rising edge where
  // write_enb is non-zero (or while discarding a packet in DROP); otherwise the
  // source keeps the same byte and pkt_valid on its inputs.
  typedef enum logic [2:0] {
    IDLE            = 3'd0,
    WAIT_EMPTY      = 3'd1,
    LOAD_FIRST      = 3'd2,
    LOAD_DATA       = 3'd3,
    FIFO_FULL       = 3'd4,
    LOAD_AFTER_FULL = 3'd5,
    CHECK_PARITY    = 3'd6,
    DROP            = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_addr;
  logic [7:0] r_acc;
  logic [7:0] r_par_byte;
  logic       r_busy;
  logic       r_lfd;
  logic       r_parity_err;
  logic [2:0] w_soft_reset;
  logic       w_sr_hit;
  logic       w_wr;
  logic       w_hdr_routable;

  function automatic logic busy_of(input state_t s);
    return (s == WAIT_EMPTY) || (s == LOAD_FIRST) || (s == FIFO_FULL) ||
           (s == LOAD_AFTER_FULL) || (s == CHECK_PARITY);
  endfunction

  assign valid_out      = ~fifo_empty;
  assign w_hdr_routable = pkt_valid && (data_in[1:0] != 2'd3);
  assign w_sr_hit       = w_soft_reset[r_addr];

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (pkt_valid) begin
          if (data_in[1:0] == 2'd3)          w_next_state = DROP;
          else if (fifo_empty[data_in[1:0]]) w_next_state = LOAD_FIRST;
          else                               w_next_state = WAIT_EMPTY;
        end
      end
      WAIT_EMPTY:      if (fifo_empty[r_addr]) w_next_state = LOAD_FIRST;
      LOAD_FIRST:      w_next_state = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full[r_addr]) w_next_state = FIFO_FULL;
        else if (!pkt_valid)   w_next_state = CHECK_PARITY;
      end
      FIFO_FULL:       if (!fifo_full[r_addr]) w_next_state = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: w_next_state = pkt_valid ? LOAD_DATA : CHECK_PARITY;
      CHECK_PARITY:    w_next_state = IDLE;
      DROP:            if (!pkt_valid) w_next_state = IDLE;
      default:         w_next_state = IDLE;
    endcase
    // A flush of the destination FIFO abandons the packet in flight.
    if (w_sr_hit && (r_state != IDLE) && (r_state != DROP)) w_next_state = IDLE;
  end

  always_comb begin
    w_wr = 1'b0;
    case (r_state)
      LOAD_FIRST:      w_wr = 1'b1;
      LOAD_DATA:       w_wr = !fifo_full[r_addr];
      LOAD_AFTER_FULL: w_wr = 1'b1;
      default:         w_wr = 1'b0;
    endcase
    if (w_sr_hit) w_wr = 1'b0;
  end

  assign write_enb = w_wr ? (3'b001 << r_addr) : 3'b000;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_addr       <= 2'd0;
      r_acc        <= 8'd0;
      r_par_byte   <= 8'd0;
      r_busy       <= 1'b0;
      r_lfd        <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= busy_of(w_next_state);
      r_lfd   <= (w_next_state == LOAD_FIRST);
      if ((r_state == IDLE) && w_hdr_routable) r_addr <= data_in[1:0];
      if (w_wr) begin
        if (r_state == LOAD_FIRST) begin
          r_acc        <= data_in;
          r_parity_err <= 1'b0;
        end else if (pkt_valid) begin
          r_acc <= r_acc ^ data_in;
        end else begin
          r_par_byte <= data_in;
        end
      end
      if ((r_state == CHECK_PARITY) && !w_sr_hit) r_parity_err <= (r_acc != r_par_byte);
    end
  end

  assign busy        = r_busy;
  assign lfd_state   = r_lfd;
  assign parity_err  = r_parity_err;
  assign o_state_dbg = r_state;

`ifdef ROUTER_CTRL_TIMEOUT_EN
  logic [4:0] r_cnt [3];
  logic [2:0] r_soft_reset;

  // A read in the terminal cycle restarts the count instead of flushing.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 3; i++) r_cnt[i] <= 5'd0;
      r_soft_reset <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (read_enb[i] || !valid_out[i]) begin
          r_cnt[i]        <= 5'd0;
          r_soft_reset[i] <= 1'b0;
        end else if (r_cnt[i] == 5'(TIMEOUT - 1)) begin
          r_cnt[i]        <= 5'd0;
          r_soft_reset[i] <= 1'b1;
        end else begin
          r_cnt[i]        <= r_cnt[i] + 5'd1;
          r_soft_reset[i] <= 1'b0;
        end
      end
    end
  end

  assign w_soft_reset = r_soft_reset;
`else
  logic w_unused_read_enb;
  assign w_unused_read_enb = ^read_enb;
  assign w_soft_reset      = 3'b000;
`endif

  assign soft_reset = w_soft_reset;

endmodule

// File: doc/router_ctrl.md
ROUTER_CTRL -- requirements
Module: router_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 30, idle cycles before a destination port is soft-reset; legal 2..31.
REQ-002 clock  input  1  sole clock; all state changes on posedge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 pkt_valid  input  1  source byte qualifier; high for header and payload, low on parity byte.
REQ-005 data_in  input  8  source byte; header: [1:0] destination, [7:2] payload length.
REQ-006 fifo_full  input  3  per-destination FIFO full.
REQ-007 fifo_empty  input  3  per-destination FIFO empty.
REQ-008 read_enb  input  3  per-destination read strobe from destination side.
REQ-009 valid_out  output  3  per-destination data-available indication.
REQ-010 write_enb  output  3  one-hot FIFO write strobe.
REQ-011 soft_reset  output  3  per-destination FIFO flush pulse.
REQ-012 busy  output  1  source stall; source holds data_in while high.
REQ-013 lfd_state  output  1  high while header byte is written.
REQ-014 parity_err  output  1  registered parity-mismatch flag.

Function
REQ-015 valid_out SHALL equal ~fifo_empty, combinationally.
REQ-016 States SHALL be IDLE, WAIT_EMPTY, LOAD_FIRST, LOAD_DATA, FIFO_FULL, LOAD_AFTER_FULL, CHECK_PARITY, DROP.
REQ-017 IDLE: pkt_valid and data_in[1:0]!=3 SHALL latch addr; fifo_empty[addr] -> LOAD_FIRST, else -> WAIT_EMPTY; pkt_valid with addr 3 -> DROP; busy=0.
REQ-018 WAIT_EMPTY: busy=1; fifo_empty[addr] -> LOAD_FIRST, else stay.
REQ-019 LOAD_FIRST: busy=1, lfd_state=1, write_enb[addr]=1, parity accumulator loaded with data_in, parity_err cleared; -> LOAD_DATA.
REQ-020 LOAD_DATA: busy=0; fifo_full[addr] -> FIFO_FULL with no write; else write_enb[addr]=1; pkt_valid=1 XORs byte into accumulator and stays; pkt_valid=0 treats byte as parity -> CHECK_PARITY.
REQ-021 FIFO_FULL: busy=1, no write; !fifo_full[addr] -> LOAD_AFTER_FULL.
REQ-022 LOAD_AFTER_FULL: busy=1, writes held byte; pkt_valid -> LOAD_DATA (byte accumulated), else -> CHECK_PARITY (byte is parity).
REQ-023 CHECK_PARITY: busy=1; parity_err <= (accumulator != captured parity byte); -> IDLE.
REQ-024 DROP: busy=0, no writes; !pkt_valid -> IDLE.
REQ-025 write_enb SHALL be zero or one-hot; never asserted outside LOAD_FIRST/LOAD_DATA/LOAD_AFTER_FULL.
REQ-026 Timeout counter per port (5 bits): increments while valid_out[i] & !read_enb[i]; clears on read_enb[i] or !valid_out[i].
REQ-027 Counter reaching TIMEOUT-1 SHALL pulse soft_reset[i] one cycle next cycle and clear; read_enb[i] in the same cycle wins (no pulse).
REQ-028 soft_reset[addr] while state not IDLE/DROP SHALL force IDLE next cycle, no further writes; parity_err unchanged.
REQ-029 parity_err SHALL hold until the next LOAD_FIRST.

Reset
REQ-030 resetn low SHALL immediately force state IDLE, addr 0, counters 0, accumulator 0, write_enb 0, soft_reset 0, busy 0, lfd_state 0, parity_err 0; mid-packet reset discards the packet.

Configuration
REQ-031 ROUTER_CTRL_TIMEOUT_EN defined: timeout counters and soft_reset per REQ-026..028; undefined: counters absent, soft_reset tied 0, REQ-028 inactive.

Verification
REQ-032 Header 0x0D (dest 1, len 3), 3 payload bytes, parity 0x0D^b1^b2^b3, port 1 empty -> write_enb=3'b010 for 5 cycles, parity_err=0.
REQ-033 Same packet, wrong parity byte -> parity_err=1 one cycle after parity write, cleared on next header.
REQ-034 fifo_full[1] high mid-payload for 4 cycles -> busy=1, no write, held byte written once after release, byte order intact.
REQ-035 Header with dest 3, 4 bytes -> no write_enb, busy=0, IDLE after pkt_valid drops.
REQ-036 TIMEOUT_EN, port 2 valid_out=1, read_enb=0 for 30 cycles -> soft_reset[2] single pulse; read_enb on cycle 29 -> no pulse.
REQ-037 resetn low during LOAD_DATA -> all outputs 0 same cycle, next packet processed normally.
